// File: rtl/memread_addr_gen.sv
// memread_addr_gen: row-major 2-D tile address walker that feeds an external pipelined row*stride multiplier; optional MEMREAD_ADDR_BOUNDS_EN adds an address-limit clamp
module memread_addr_gen #(
  parameter int MUL_LAT = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       cfg_base,
  input  logic [15:0]       cfg_cols,
  input  logic [13:0]       cfg_rows,
  input  logic [15:0]       cfg_stride,
  output logic              busy,
  output logic              done,
  output logic [13:0]       mul_a,
  output logic [15:0]       mul_b,
  output logic              mul_ce,
  input  logic [29:0]       mul_p,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready
`ifdef MEMREAD_ADDR_BOUNDS_EN
  ,
  input  logic [31:0]       addr_limit,
  output logic              oob_err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] base;
  logic [15:0] cols, stride, col;
  logic [13:0] rows, row;
  logic sb_v [MUL_LAT];
  logic sb_l [MUL_LAT];
  logic [15:0] sb_c [MUL_LAT];
  logic addr_last, adv, issue, last_beat;
  logic [ADDR_W-1:0] sum, nxt;
  assign adv = ~(addr_valid & ~addr_ready);
  assign mul_ce = adv;
  assign mul_a = row;
  assign mul_b = stride;
  assign issue = (state == RUN) && adv;
  assign last_beat = (row == rows - 14'd1) && (col == cols - 16'd1);
  assign sum = ADDR_W'(base) + ADDR_W'(mul_p) + ADDR_W'(sb_c[MUL_LAT-1]);
`ifdef MEMREAD_ADDR_BOUNDS_EN
  logic clamp;
  assign clamp = sum >= ADDR_W'(addr_limit);
  assign nxt = clamp ? ADDR_W'(addr_limit) - ADDR_W'(1) : sum;
`else
  assign nxt = sum;
`endif
  // control FSM: latches the tile on start and walks row/col one beat per unstalled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      base <= '0;
      cols <= '0;
      rows <= '0;
      stride <= '0;
      row <= '0;
      col <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base <= cfg_base;
          cols <= cfg_cols;
          rows <= cfg_rows;
          stride <= cfg_stride;
          row <= '0;
          col <= '0;
          busy <= 1'b1;
          state <= (cfg_cols == '0 || cfg_rows == '0) ? DONE : RUN;
          done <= (cfg_cols == '0 || cfg_rows == '0);
        end
        RUN: if (adv) begin
          col <= (col == cols - 16'd1) ? '0 : col + 16'd1;
          row <= (col == cols - 16'd1) ? row + 14'd1 : row;
          state <= last_beat ? DRAIN : RUN;
        end
        DRAIN: if (addr_valid && addr_ready && addr_last) begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // sideband shift register aligned with the multiplier latency, plus the output register; all frozen on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        sb_v[i] <= 1'b0;
        sb_l[i] <= 1'b0;
        sb_c[i] <= '0;
      end
      addr <= '0;
      addr_valid <= 1'b0;
      addr_last <= 1'b0;
`ifdef MEMREAD_ADDR_BOUNDS_EN
      oob_err <= 1'b0;
`endif
    end else begin
`ifdef MEMREAD_ADDR_BOUNDS_EN
      if (state == IDLE && start) oob_err <= 1'b0;
      else if (adv && sb_v[MUL_LAT-1] && clamp) oob_err <= 1'b1;
`endif
      if (adv) begin
        sb_v[0] <= issue;
        sb_l[0] <= issue && last_beat;
        sb_c[0] <= col;
        for (int i = 1; i < MUL_LAT; i++) begin
          sb_v[i] <= sb_v[i-1];
          sb_l[i] <= sb_l[i-1];
          sb_c[i] <= sb_c[i-1];
        end
        addr <= nxt;
        addr_valid <= sb_v[MUL_LAT-1];
        addr_last <= sb_l[MUL_LAT-1];
      end
    end
  end
endmodule

// File: tb/tb_memread_addr_gen.sv
// tb_memread_addr_gen: scoreboard bench with a behavioural 3-stage multiplier
module tb_memread_addr_gen;
  logic clk = 0, reset = 0, start = 0, addr_ready = 1;
  logic [31:0] cfg_base = 0;
  logic [15:0] cfg_cols = 0, cfg_stride = 0;
  logic [13:0] cfg_rows = 0;
  logic busy, done, mul_ce, addr_valid;
  logic [13:0] mul_a;
  logic [15:0] mul_b;
  logic [29:0] mul_p, m0, m1, m2;
  logic [31:0] addr;
`ifdef MEMREAD_ADDR_BOUNDS_EN
  logic [31:0] addr_limit = 32'hFFFF_FFFF;
  logic oob_err;
`endif
  logic [31:0] q[$];
  int passed = 0, total = 0, cyc = 0, n_acc = 0, acc_cyc = 0, first_v = -1, k = 0;

  memread_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_cols(cfg_cols),
    .cfg_rows(cfg_rows), .cfg_stride(cfg_stride), .busy(busy), .done(done),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready)
`ifdef MEMREAD_ADDR_BOUNDS_EN
    , .addr_limit(addr_limit), .oob_err(oob_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mul_ce) begin
    m0 <= 30'(mul_a) * 30'(mul_b);
    m1 <= m0;
    m2 <= m1;
  end
  assign mul_p = m2;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  function automatic logic [31:0] ex(input logic [31:0] a);
`ifdef MEMREAD_ADDR_BOUNDS_EN
    return (a >= addr_limit) ? addr_limit - 32'd1 : a;
`else
    return a;
`endif
  endfunction

  task automatic push_tile1();
    q.push_back(ex(32'h1000)); q.push_back(ex(32'h1001)); q.push_back(ex(32'h1002));
    q.push_back(ex(32'h1008)); q.push_back(ex(32'h1009)); q.push_back(ex(32'h100A));
  endtask

  task automatic go(input logic [31:0] b, input logic [15:0] w, input logic [13:0] h, input logic [15:0] s);
    @(posedge clk); #1;
    cfg_base = b; cfg_cols = w; cfg_rows = h; cfg_stride = s;
    start = 1; n_acc = 0; first_v = -1; k = cyc;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin @(negedge clk); t++; end
    chk("done_seen", done, 1);
    chk("done_after_last_accept", cyc, acc_cyc + 1);
    chk("queue_drained", q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_clear", busy, 0);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 300) begin @(posedge clk); #1; t++; end
    chk("reach_beat", n_acc, n);
  endtask

  always @(negedge clk) if (!reset && addr_valid) begin
    if (first_v < 0) first_v = cyc;
    if (q.size() == 0) chk("unexpected_addr_valid", addr_valid, 0);
    else if (addr_ready) begin
      chk("addr", addr, q.pop_front());
      n_acc++;
      acc_cyc = cyc;
    end else begin
      chk("stall_addr_hold", addr, q[0]);
      chk("stall_mul_ce", mul_ce, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1;
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0); chk("rst_mul_a", mul_a, 0); chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_ce", mul_ce, 1);
`ifdef MEMREAD_ADDR_BOUNDS_EN
    chk("rst_oob", oob_err, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 0;
    // basic tile, ready high
    push_tile1();
    go(32'h1000, 3, 2, 8);
    wait_done();
    chk("first_valid_latency", first_v, k + 5);
    chk("throughput", acc_cyc - first_v, 5);
    // stall for 5 cycles on the 2nd beat
    push_tile1();
    go(32'h1000, 3, 2, 8);
    wait_acc(1);
    addr_ready = 0;
    repeat (5) @(posedge clk);
    #1 addr_ready = 1;
    wait_done();
    chk("stall_beats", n_acc, 6);
    // empty tile
    go(32'h2000, 0, 5, 4);
    @(negedge clk);
    chk("empty_busy", busy, 1); chk("empty_done", done, 1);
    @(negedge clk);
    chk("empty_busy_off", busy, 0); chk("empty_done_off", done, 0);
    repeat (4) @(negedge clk);
    chk("empty_no_valid", addr_valid, 0);
    // reset mid-walk, then a clean restart
    push_tile1();
    go(32'h1000, 3, 2, 8);
    wait_acc(2);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_addr", addr, 0);
    chk("abort_valid", addr_valid, 0); chk("abort_mul_a", mul_a, 0); chk("abort_mul_b", mul_b, 0);
    chk("abort_mul_ce", mul_ce, 1);
    q.delete();
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_no_done", done, 0);
    push_tile1();
    go(32'h1000, 3, 2, 8);
    wait_done();
    chk("restart_beats", n_acc, 6);
    // multi-row tile with large stride
    q.push_back(ex(32'h0040)); q.push_back(ex(32'h0041));
    q.push_back(ex(32'h0140)); q.push_back(ex(32'h0141));
    q.push_back(ex(32'h0240)); q.push_back(ex(32'h0241));
    go(32'h0040, 2, 3, 16'h0100);
    wait_done();
    // address wrap
    q.push_back(ex(32'hFFFF_FFFE)); q.push_back(ex(32'hFFFF_FFFF));
    q.push_back(ex(32'h0000_0000)); q.push_back(ex(32'h0000_0001));
    go(32'hFFFF_FFFE, 4, 1, 1);
    wait_done();
`ifdef MEMREAD_ADDR_BOUNDS_EN
    addr_limit = 32'h1005;
    push_tile1();
    go(32'h1000, 3, 2, 8);
    chk("oob_cleared_by_start", oob_err, 0);
    wait_acc(3);
    chk("oob_set_first_clamp", oob_err, 1);
    wait_done();
    chk("oob_sticky", oob_err, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
